// File: rtl/times_5_pkg.sv
// rtl/times_5_pkg.sv - shared types, default widths and the times-5 helper
package times_5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_W_DEF     = 16;
  localparam int OUT_W_DEF      = DATA_W_DEF + 3;
  localparam int NUM_PIXELS_DEF = 64;

  // Shift-and-add keeps the multiply out of a DSP; 3 guard bits absorb the growth.
  function automatic logic [34:0] times5(input logic [31:0] x);
    return ({3'b000, x} << 2) + {3'b000, x};
  endfunction

endpackage

// File: rtl/hs_out_slot.sv
// rtl/hs_out_slot.sv - one-entry ap_hs output register with independent value/last halves
module hs_out_slot #(
  parameter int OUT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [OUT_W-1:0] load_value,
  input  logic             load_last,
  output logic [OUT_W-1:0] value,
  output logic             value_vld,
  input  logic             value_ack,
  output logic             last,
  output logic             last_vld,
  input  logic             last_ack,
  output logic             free,
  output logic             free_next,
  output logic             done
);

  logic value_done;
  logic last_done;

  // A half is complete once acked, whether in an earlier cycle or right now.
  assign value_done = !value_vld || value_ack;
  assign last_done  = !last_vld || last_ack;
  assign free       = !value_vld && !last_vld;
  assign free_next  = value_done && last_done;
  assign done       = (value_vld || last_vld) && free_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= '0;
      last      <= 1'b0;
      value_vld <= 1'b0;
      last_vld  <= 1'b0;
    end else if (load) begin
      value     <= load_value;
      last      <= load_last;
      value_vld <= 1'b1;
      last_vld  <= 1'b1;
    end else begin
      value_vld <= value_vld && !value_ack;
      last_vld  <= last_vld && !last_ack;
    end
  end

endmodule

// File: rtl/times_5_hs_core.sv
// rtl/times_5_hs_core.sv - ap_ctrl_hs streaming kernel: FIFO in, x5, ap_hs out
module times_5_hs_core
  import times_5_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OUT_W      = DATA_W + 3,
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int CNT_W      = $clog2(NUM_PIXELS + 1)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] in_value_dout,
  input  logic              in_value_empty_n,
  output logic              in_value_read,
  input  logic              in_last_dout,
  input  logic              in_last_empty_n,
  output logic              in_last_read,
  output logic [OUT_W-1:0]  out_value,
  output logic              out_value_ap_vld,
  input  logic              out_value_ap_ack,
  output logic              out_last,
  output logic              out_last_ap_vld,
  input  logic              out_last_ap_ack,
  output logic              err_last
);

  localparam logic [CNT_W-1:0] N_PIX    = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             rd;
  logic             is_last_in;
  logic             final_out;
  logic             slot_free;
  logic             slot_free_next;
  logic             slot_done;
  logic [OUT_W-1:0] load_value;

  assign is_last_in = (in_cnt == LAST_IDX);
  assign final_out  = slot_done && (out_cnt == LAST_IDX);
  assign load_value = OUT_W'(times5(32'(in_value_dout)));

  // Reading while the pending slot drains this cycle gives 1 pixel/cycle.
  assign rd = (state == RUN) && (in_cnt < N_PIX) && in_value_empty_n &&
              in_last_empty_n && (slot_free || slot_free_next);

  assign in_value_read = rd;
  assign in_last_read  = rd;
  assign ap_ready      = rd && is_last_in;
  assign ap_idle       = (state == IDLE);
  assign ap_done       = (state == DONE);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ap_start) state_nxt = RUN;
      RUN:     if (rd && is_last_in) state_nxt = final_out ? DONE : DRAIN;
      DRAIN:   if (final_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      err_last <= 1'b0;
    end else begin
      if (state == IDLE && ap_start) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd) in_cnt <= in_cnt + 1'b1;
        if (slot_done) out_cnt <= out_cnt + 1'b1;
      end
      // Sticky: the data still flows, the flag only reports the framing mismatch.
      if (rd && (in_last_dout != is_last_in)) err_last <= 1'b1;
    end
  end

  hs_out_slot #(
    .OUT_W(OUT_W)
  ) u_slot (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .load      (rd),
    .load_value(load_value),
    .load_last (is_last_in),
    .value     (out_value),
    .value_vld (out_value_ap_vld),
    .value_ack (out_value_ap_ack),
    .last      (out_last),
    .last_vld  (out_last_ap_vld),
    .last_ack  (out_last_ap_ack),
    .free      (slot_free),
    .free_next (slot_free_next),
    .done      (slot_done)
  );

endmodule

// File: tb/tb_times_5_hs_core.sv
// tb/tb_times_5_hs_core.sv - scoreboard bench for times_5_hs_core with NUM_PIXELS=4
module tb_times_5_hs_core;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 19;
  localparam int NPIX   = 4;
  localparam int CNT_W  = 3;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done, ap_idle, ap_ready;
  logic [DATA_W-1:0] in_value_dout;
  logic              in_value_empty_n, in_value_read;
  logic              in_last_dout, in_last_empty_n, in_last_read;
  logic [OUT_W-1:0]  out_value;
  logic              out_value_ap_vld, out_value_ap_ack;
  logic              out_last, out_last_ap_vld, out_last_ap_ack;
  logic              err_last;

  times_5_hs_core #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_PIXELS(NPIX), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .in_value_dout(in_value_dout), .in_value_empty_n(in_value_empty_n),
    .in_value_read(in_value_read), .in_last_dout(in_last_dout),
    .in_last_empty_n(in_last_empty_n), .in_last_read(in_last_read),
    .out_value(out_value), .out_value_ap_vld(out_value_ap_vld),
    .out_value_ap_ack(out_value_ap_ack), .out_last(out_last),
    .out_last_ap_vld(out_last_ap_vld), .out_last_ap_ack(out_last_ap_ack),
    .err_last(err_last)
  );

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input FIFO model
  logic [DATA_W-1:0] fv [0:63];
  logic              fl [0:63];
  int wp = 0;
  int rp = 0;
  bit starve_last = 0;

  assign in_value_dout    = fv[rp[5:0]];
  assign in_last_dout     = fl[rp[5:0]];
  assign in_value_empty_n = (rp < wp);
  assign in_last_empty_n  = (rp < wp) && !starve_last;

  always @(posedge ap_clk) begin
    cyc <= cyc + 1;
    if (!ap_rst_n) rp <= 0;
    else if (in_value_read) rp <= rp + 1;
  end

  // Scoreboard queues and event logs
  int exp_v[$];
  bit exp_l[$];
  int rd_cyc[$];
  int vhs_cyc[$];
  int ready_cyc = -1;
  int done_cyc = -1;
  int ready_cnt = 0;
  int done_cnt = 0;

  task automatic load_px(input int v, input bit in_last, input bit exp_last);
    fv[wp[5:0]] = v[DATA_W-1:0];
    fl[wp[5:0]] = in_last;
    wp++;
    exp_v.push_back(v * 5);
    exp_l.push_back(exp_last);
  endtask

  // Ack generator: mode 0 ties acks high, mode 1 delays value by 3 and last by 1
  int ack_mode = 0;
  int vcnt = 0;
  int lcnt = 0;
  always @(posedge ap_clk) begin
    #1;
    if (ack_mode == 0) begin
      out_value_ap_ack = 1'b1;
      out_last_ap_ack  = 1'b1;
      vcnt = 0;
      lcnt = 0;
    end else begin
      out_value_ap_ack = out_value_ap_vld && (vcnt == 3);
      out_last_ap_ack  = out_last_ap_vld && (lcnt == 1);
      vcnt = (out_value_ap_vld && !out_value_ap_ack) ? vcnt + 1 : 0;
      lcnt = (out_last_ap_vld && !out_last_ap_ack) ? lcnt + 1 : 0;
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake
  bit prev_vv = 0, prev_va = 0, prev_lv = 0, prev_la = 0;
  logic [OUT_W-1:0] prev_val = '0;
  logic prev_l = 1'b0;
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (out_value_ap_vld && out_value_ap_ack) begin
        vhs_cyc.push_back(cyc);
        if (exp_v.size() == 0) chk("unexpected_value", 32'(out_value), 0);
        else chk("out_value", 32'(out_value), 32'(exp_v.pop_front()));
      end
      if (out_last_ap_vld && out_last_ap_ack) begin
        if (exp_l.size() == 0) chk("unexpected_last", 32'(out_last), 0);
        else chk("out_last", 32'(out_last), 32'(exp_l.pop_front()));
      end
      if (prev_vv && !prev_va) begin
        chk("value_vld_held", 32'(out_value_ap_vld), 1);
        chk("value_stable", 32'(out_value), 32'(prev_val));
      end
      if (prev_lv && !prev_la) chk("last_stable", 32'(out_last), 32'(prev_l));
      if (in_value_read || in_last_read) begin
        rd_cyc.push_back(cyc);
        chk("read_pair", 32'(in_last_read), 32'(in_value_read));
      end
      if (ap_ready) begin
        ready_cyc = cyc;
        ready_cnt++;
        chk("ready_with_read", 32'(in_value_read), 1);
      end
      if (ap_done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      prev_vv  = out_value_ap_vld;
      prev_va  = out_value_ap_ack;
      prev_val = out_value;
      prev_lv  = out_last_ap_vld;
      prev_la  = out_last_ap_ack;
      prev_l   = out_last;
    end else begin
      prev_vv = 0;
      prev_lv = 0;
    end
  end

  task automatic pulse_start();
    @(posedge ap_clk); #1 ap_start = 1'b1;
    @(posedge ap_clk); #1 ap_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(posedge ap_clk);
    chk(name, 32'(done_cnt - d0), 1);
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    vhs_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_idle"}, 32'(ap_idle), 1);
    chk({tag, "_done"}, 32'(ap_done), 0);
    chk({tag, "_ready"}, 32'(ap_ready), 0);
    chk({tag, "_read"}, 32'({in_value_read, in_last_read}), 0);
    chk({tag, "_vld"}, 32'({out_value_ap_vld, out_last_ap_vld}), 0);
    chk({tag, "_out_value"}, 32'(out_value), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_err"}, 32'(err_last), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    int d_first;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    out_value_ap_ack = 1'b1;
    out_last_ap_ack = 1'b1;

    // Reset then idle
    repeat (2) @(posedge ap_clk);
    #1 check_reset_outputs("in_reset");
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check_reset_outputs("post_reset");
    nrd = rd_cyc.size();
    repeat (10) @(posedge ap_clk);
    chk("idle_no_read", 32'(rd_cyc.size() - nrd), 0);
    chk("idle_still", 32'(ap_idle), 1);

    // Basic run at full rate
    clear_logs();
    load_px(1, 0, 0); load_px(2, 0, 0); load_px(3, 0, 0); load_px(1000, 1, 1);
    pulse_start();
    wait_done("basic_done");
    chk("basic_reads", 32'(rd_cyc.size()), 4);
    chk("basic_outs", 32'(vhs_cyc.size()), 4);
    if (rd_cyc.size() == 4 && vhs_cyc.size() == 4) begin
      chk("basic_read_span", 32'(rd_cyc[3] - rd_cyc[0]), 3);
      chk("basic_out_span", 32'(vhs_cyc[3] - vhs_cyc[0]), 3);
      chk("basic_latency", 32'(vhs_cyc[0] - rd_cyc[0]), 1);
      chk("basic_ready_cyc", 32'(ready_cyc), 32'(rd_cyc[3]));
      chk("basic_done_cyc", 32'(done_cyc), 32'(rd_cyc[3] + 2));
    end
    chk("basic_ready_cnt", 32'(ready_cnt), 1);
    chk("basic_err", 32'(err_last), 0);
    chk("basic_sb_empty", 32'(exp_v.size() + exp_l.size()), 0);

    // Backpressure with skewed acks
    clear_logs();
    @(posedge ap_clk); #1 ack_mode = 1;
    load_px(7, 0, 0); load_px(100, 0, 0); load_px(13107, 0, 0); load_px(42, 1, 1);
    pulse_start();
    wait_done("bp_done");
    chk("bp_outs", 32'(vhs_cyc.size()), 4);
    if (rd_cyc.size() == 4 && vhs_cyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("bp_read_after_ack", 32'(rd_cyc[k]), 32'(vhs_cyc[k-1]));
    chk("bp_sb_empty", 32'(exp_v.size() + exp_l.size()), 0);
    @(posedge ap_clk); #1 ack_mode = 0;

    // Starved last FIFO
    clear_logs();
    starve_last = 1;
    load_px(9, 0, 0); load_px(8, 0, 0); load_px(6, 0, 0); load_px(5, 1, 1);
    pulse_start();
    nrd = rd_cyc.size();
    repeat (5) @(posedge ap_clk);
    chk("starve_no_read", 32'(rd_cyc.size() - nrd), 0);
    chk("starve_not_idle", 32'(ap_idle), 0);
    #1 starve_last = 0;
    wait_done("starve_done");
    chk("starve_reads", 32'(rd_cyc.size()), 4);
    chk("starve_sb_empty", 32'(exp_v.size() + exp_l.size()), 0);

    // Max value with a misplaced input last
    load_px(65535, 1, 0); load_px(0, 0, 0); load_px(0, 0, 0); load_px(7, 1, 1);
    pulse_start();
    wait_done("max_done");
    chk("max_err_set", 32'(err_last), 1);
    repeat (3) @(posedge ap_clk);
    chk("max_err_held", 32'(err_last), 1);
    chk("max_sb_empty", 32'(exp_v.size() + exp_l.size()), 0);

    // Mid-run reset after two pixels
    clear_logs();
    nrd = done_cnt;
    load_px(11, 0, 0); load_px(12, 0, 0);
    pulse_start();
    for (int i = 0; i < 50 && vhs_cyc.size() < 2; i++) @(posedge ap_clk);
    chk("mid_two_outs", 32'(vhs_cyc.size()), 2);
    #1 ap_rst_n = 1'b0;
    wp = 0;
    exp_v.delete();
    exp_l.delete();
    @(posedge ap_clk); #1;
    check_reset_outputs("mid_reset");
    ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    chk("mid_no_done", 32'(done_cnt - nrd), 0);
    chk("mid_idle", 32'(ap_idle), 1);
    load_px(20, 0, 0); load_px(21, 0, 0); load_px(22, 0, 0); load_px(23, 1, 1);
    pulse_start();
    wait_done("restart_done");
    chk("restart_err", 32'(err_last), 0);

    // ap_start held high across DONE: two back-to-back runs
    clear_logs();
    for (int k = 0; k < 8; k++) load_px(300 + k, (k % 4) == 3, (k % 4) == 3);
    @(posedge ap_clk); #1 ap_start = 1'b1;
    wait_done("b2b_done1");
    d_first = done_cyc;
    wait_done("b2b_done2");
    #1 ap_start = 1'b0;
    chk("b2b_reads", 32'(rd_cyc.size()), 8);
    if (rd_cyc.size() == 8) chk("b2b_gap", 32'(rd_cyc[4]), 32'(d_first + 2));
    repeat (3) @(posedge ap_clk);
    chk("b2b_idle", 32'(ap_idle), 1);
    chk("b2b_sb_empty", 32'(exp_v.size() + exp_l.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/times_5_hs_core.md
Name: times_5_hs_core

Overview:
- Streaming kernel core that answers the ap_ctrl_hs block-level handshake (ap_start/ap_done/ap_idle/ap_ready) driven by a controller or testbench.
- Per run it consumes NUM_PIXELS words from an input FIFO interface (dout/empty_n/read), multiplies each by 5, and emits results on an ap_hs output interface (ap_vld/ap_ack) with a last flag.
- It is the responder end of the top-level control protocol, i.e. the hardware the "top" wrapper instantiates.

Parameters:
- DATA_W, 16, input pixel width, unsigned.
- OUT_W, DATA_W+3, output width; holds 5*(2^DATA_W-1) without overflow.
- NUM_PIXELS, 64, pixels per run (>=1).
- CNT_W, $clog2(NUM_PIXELS+1), counter width.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  run request.
- ap_done  out  1  one-cycle pulse when the final output is acked.
- ap_idle  out  1  high when no run is active.
- ap_ready  out  1  one-cycle pulse on the cycle the final input is read.
- in_value_dout  in  DATA_W  input FIFO data.
- in_value_empty_n  in  1  input value FIFO non-empty.
- in_value_read  out  1  pop the input value FIFO.
- in_last_dout  in  1  input last flag.
- in_last_empty_n  in  1  last FIFO non-empty.
- in_last_read  out  1  pop the last FIFO.
- out_value  out  OUT_W  result.
- out_value_ap_vld  out  1  result valid.
- out_value_ap_ack  in  1  result accepted.
- out_last  out  1  high on the final pixel of the run.
- out_last_ap_vld  out  1  last valid.
- out_last_ap_ack  in  1  last accepted.
- err_last  out  1  sticky flag: input last disagreed with the pixel count.

Behaviour:
Reset (async assert, sync deassert, ap_rst_n=0):
- State IDLE, ap_idle=1.
- All other outputs 0: ap_done, ap_ready, in_*_read, out_*_ap_vld, out_value, out_last, err_last.
- Counters cleared.
- Reset mid-run aborts the run immediately; no done pulse is produced.

States:
- IDLE: ap_idle=1. ap_start=1 sampled at a rising edge -> RUN. The in_cnt and out_cnt counters clear. err_last holds its value until reset.
- RUN: reads inputs and emits outputs. After the final read -> DRAIN (or straight to DONE if the final output is acked in the same cycle).
- DRAIN: waits until the final output is fully acked -> DONE.
- DONE: ap_done=1 for exactly this one cycle -> IDLE.
  - ap_start held high restarts from the next IDLE cycle, giving a minimum one-cycle gap between runs.
- ap_idle=0 in RUN, DRAIN and DONE.
- ap_start is ignored outside IDLE.

Input read:
- in_value_read and in_last_read are always equal, combinational, and asserted only when all of these hold:
  - state is RUN;
  - in_cnt < NUM_PIXELS;
  - both empty_n are 1;
  - the output slot is free, or it will be freed this cycle.
- The slot is freed this cycle when both ap_hs halves are complete: each half has had its ack this cycle or earlier.
- Data is consumed on the same edge as the read.
- If only one FIFO is non-empty, nothing is read.

Output register (single slot):
- On a read: out_value <= (in_value_dout<<2) + in_value_dout, zero-extended to OUT_W.
- out_last <= (in_cnt == NUM_PIXELS-1).
- Both ap_vld go to 1 on the next cycle, so latency is 1 cycle from read to vld.
- The value and last halves are tracked independently:
  - each half's vld drops on the cycle after its ack;
  - the slot is free once both halves are acked;
  - acks may arrive in the same or different cycles.
- Data and vld stay stable until acked.
- Ack with vld=0 is ignored.
- A read in the same cycle the final pending ack arrives reloads the slot with no bubble, giving a throughput of 1 pixel/cycle with ack tied high.

Counters and flags:
- ap_ready pulses 1 on the cycle of the read where in_cnt == NUM_PIXELS-1.
- err_last is set when in_last_dout disagrees with the expected last (in_cnt == NUM_PIXELS-1) on a read. Data still passes unchanged.
- out_cnt increments when both halves of a slot are complete; reaching NUM_PIXELS ends DRAIN.
- NUM_PIXELS=1: ap_ready pulses on the first read; out_last=1 on that pixel.

Decomposition:
- Package times_5_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - the default-width localparams;
  - function times5(x) = (x<<2)+x.
- One natural sub-module: hs_out_slot. It is the one-entry ap_hs output register with per-half vld/ack tracking and a free/free_next signal.
- The FSM, counters and read logic live in the top.

Test Plan:
- Reset then idle: hold ap_rst_n=0 for 2 cycles, release -> ap_idle=1, all other outputs 0; ap_start=0 for 10 cycles -> no reads.
- Basic run, NUM_PIXELS=4: FIFOs hold 1,2,3,1000 (last 0,0,0,1), acks tied 1, pulse ap_start 1 cycle:
  - outputs 5,10,15,5000 on 4 consecutive cycles, out_last only on 5000;
  - ap_ready pulses on the 4th read;
  - ap_done pulses 2 cycles after the 4th read;
  - err_last=0.
- Backpressure: value ack delayed 3 cycles and last ack delayed 1 cycle on each pixel -> data stable while vld; next read only after both acks; outputs in order; no loss.
- Starved input: in_value_empty_n=1 with in_last_empty_n=0 for 5 cycles -> no read, ap_idle=0; then both 1 -> resumes.
- Max value and error: DATA_W=16, input 65535 with last=1 on pixel 0 of 4 -> out_value=327675 (19 bits), err_last set and held.
- Mid-run reset and restart: assert ap_rst_n=0 after 2 pixels -> outputs 0, state IDLE, no ap_done; a new ap_start completes a full run. ap_start held high across DONE -> new run starts after a 1-cycle idle gap.
